sram_capture_ctrl: RTL and testbench

- Capture controller upstream of the SRAM tiles. Writes the time-interleaved ADC word stream into N_mem_tiles single-port SRAM tiles after an arm/trigger sequence.
- Produces the debug readback data and write pointer consumed by the JTAG debug path (in_addr, sel_sram, out_data, addr).
- Owns tile address decode, capture FSM and the read-mux pipeline.

---
 rtl/sram_capture_ctrl_pkg.sv | 23 ++
 rtl/sram_capture_ctrl_if.sv | 22 ++
 rtl/sram_capture_ctrl_readback_mux.sv | 40 ++++
 rtl/sram_capture_ctrl.sv | 141 ++++++++++++++
 tb/tb_sram_capture_ctrl.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/sram_capture_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// const_pack : shared widths and capture-FSM state type for the SRAM capture path
// Revision   : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package const_pack;

   localparam int N_mem_addr = 4;
   localparam int Nadc       = 8;
   localparam int Nti        = 2;
   localparam int Nti_rep    = 2;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARMED   = 2'd1,
      CAPTURE = 2'd2,
      DONE    = 2'd3
   } sram_cap_state_t;

endpackage

`default_nettype wire

// File: rtl/sram_capture_ctrl_if.sv
// ----------------------------------------------------------------------------
// sram_capture_ctrl_if : shared write/read bus between the capture controller and the SRAM tiles
// Revision             : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface sram_capture_ctrl_if #(
   parameter int N_mem_tiles = 4,
   parameter int N_mem_addr  = const_pack::N_mem_addr,
   parameter int Nadc        = const_pack::Nadc,
   parameter int Nlanes      = const_pack::Nti + const_pack::Nti_rep
);
   logic [N_mem_tiles-1:0]  mem_wr_en;
   logic [N_mem_addr-1:0]   mem_addr;
   logic signed [Nadc-1:0]  mem_wdata [Nlanes];
   logic signed [Nadc-1:0]  mem_rdata [N_mem_tiles][Nlanes];

   modport master (output mem_wr_en, output mem_addr, output mem_wdata, input  mem_rdata);
   modport slave  (input  mem_wr_en, input  mem_addr, input  mem_wdata, output mem_rdata);
endinterface

`default_nettype wire

// File: rtl/sram_capture_ctrl_readback_mux.sv
// ----------------------------------------------------------------------------
// sram_readback_mux : delays the tile index to line up with tile read data, then registers the selected word
// Revision          : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module sram_readback_mux #(
   parameter int N_mem_tiles = 4,
   parameter int Nadc        = const_pack::Nadc,
   parameter int Nlanes      = const_pack::Nti + const_pack::Nti_rep
) (
   input  wire logic                             clk,
   input  wire logic                             rstb,
   input  wire logic                             rd_vld,
   input  wire logic [$clog2(N_mem_tiles)-1:0]   rd_tile,
   input  wire logic signed [Nadc-1:0]           mem_rdata [N_mem_tiles][Nlanes],
   output      logic signed [Nadc-1:0]           out_data  [Nlanes]
);
   logic [$clog2(N_mem_tiles)-1:0] r_tile_d;
   logic                           r_vld_d;
   logic signed [Nadc-1:0]         r_out [Nlanes];

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         r_tile_d <= '0;
         r_vld_d  <= 1'b0;
         r_out    <= '{default: '0};
      end else begin
         r_tile_d <= rd_tile;
         r_vld_d  <= rd_vld;
         if (r_vld_d)
            r_out <= mem_rdata[r_tile_d];
      end
   end

   assign out_data = r_out;

endmodule

`default_nettype wire

// File: rtl/sram_capture_ctrl.sv
// ----------------------------------------------------------------------------
// sram_capture_ctrl : arm/trigger capture of the ADC word stream into N_mem_tiles SRAM tiles, plus debug readback
// Revision          : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module sram_capture_ctrl #(
   parameter int N_mem_tiles = 4,
   parameter int N_mem_addr  = const_pack::N_mem_addr,
   parameter int Nadc        = const_pack::Nadc,
   parameter int Nlanes      = const_pack::Nti + const_pack::Nti_rep
) (
   input  wire logic                                      clk,
   input  wire logic                                      rstb,
   input  wire logic signed [Nadc-1:0]                    in_data [Nlanes],
   input  wire logic                                      in_valid,
   input  wire logic                                      start,
   input  wire logic                                      abort,
   input  wire logic                                      trigger,
   sram_capture_ctrl_if.master                            mem,
   input  wire logic [N_mem_addr+$clog2(N_mem_tiles)-1:0] in_addr,
   input  wire logic                                      sel_sram,
   output      logic signed [Nadc-1:0]                    out_data [Nlanes],
   output      logic [N_mem_addr+$clog2(N_mem_tiles)-1:0] addr,
   output      logic                                      done,
   output      logic                                      busy
);
   import const_pack::*;

   localparam int TW = $clog2(N_mem_tiles);
   localparam int AW = N_mem_addr + TW;
   localparam logic [AW-1:0] c_ptr_last = '1;

   sram_cap_state_t         r_state, w_next_state;
   logic [AW-1:0]           r_wr_ptr;
   logic [AW-1:0]           r_addr;
   logic                    r_done;
   logic [N_mem_tiles-1:0]  r_mem_wr_en;
   logic [N_mem_addr-1:0]   r_mem_addr;
   logic signed [Nadc-1:0]  r_mem_wdata [Nlanes];
   logic [TW-1:0]           r_rd_tile;
   logic                    r_rd_vld;
   logic                    w_busy, w_wr_accept, w_arm, w_rd_active;

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) r_state <= IDLE;
      else       r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      if (abort) begin
         w_next_state = IDLE;
      end else begin
         case (r_state)
            IDLE, DONE: if (start)   w_next_state = ARMED;
            ARMED:      if (trigger) w_next_state = CAPTURE;
            CAPTURE:    if (in_valid && r_wr_ptr == c_ptr_last) w_next_state = DONE;
            default:    w_next_state = IDLE;
         endcase
      end
   end

   // A trigger cycle with valid data already counts as the first write.
   always_comb begin
      w_busy      = 1'b0;
      w_wr_accept = 1'b0;
      w_arm       = 1'b0;
      w_rd_active = 1'b0;
      case (r_state)
         IDLE, DONE: begin
            w_arm       = start && !abort;
            w_rd_active = sel_sram;
         end
         ARMED: begin
            w_busy      = 1'b1;
            w_wr_accept = trigger && in_valid && !abort;
         end
         CAPTURE: begin
            w_busy      = 1'b1;
            w_wr_accept = in_valid && !abort;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         r_wr_ptr    <= '0;
         r_addr      <= '0;
         r_done      <= 1'b0;
         r_mem_wr_en <= '0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '{default: '0};
         r_rd_tile   <= '0;
         r_rd_vld    <= 1'b0;
      end else begin
         r_mem_wr_en <= '0;
         r_rd_vld    <= w_rd_active;
         if (w_arm || abort)
            r_done <= 1'b0;
         if (w_arm)
            r_wr_ptr <= '0;
         if (w_wr_accept) begin
            r_mem_wr_en <= N_mem_tiles'(1) << r_wr_ptr[AW-1:N_mem_addr];
            r_mem_addr  <= r_wr_ptr[N_mem_addr-1:0];
            r_mem_wdata <= in_data;
            r_addr      <= r_wr_ptr;
            r_wr_ptr    <= r_wr_ptr + AW'(1);
            if (r_wr_ptr == c_ptr_last)
               r_done <= 1'b1;
         end else if (w_rd_active) begin
            r_mem_addr <= in_addr[N_mem_addr-1:0];
            r_rd_tile  <= in_addr[AW-1:N_mem_addr];
         end
      end
   end

   sram_readback_mux #(
      .N_mem_tiles (N_mem_tiles),
      .Nadc        (Nadc),
      .Nlanes      (Nlanes)
   ) u_readback_mux (
      .clk       (clk),
      .rstb      (rstb),
      .rd_vld    (r_rd_vld),
      .rd_tile   (r_rd_tile),
      .mem_rdata (mem.mem_rdata),
      .out_data  (out_data)
   );

   assign mem.mem_wr_en = r_mem_wr_en;
   assign mem.mem_addr  = r_mem_addr;
   assign mem.mem_wdata = r_mem_wdata;
   assign addr          = r_addr;
   assign done          = r_done;
   assign busy          = w_busy;

endmodule

`default_nettype wire

// File: tb/tb_sram_capture_ctrl.sv
// ----------------------------------------------------------------------------
// tb_sram_capture_ctrl : directed test of capture, abort, reset and readback with a 2-tile x 16-row SRAM model
// Revision             : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_sram_capture_ctrl;
   localparam int N_mem_tiles = 2;
   localparam int N_mem_addr  = 4;
   localparam int Nadc        = 8;
   localparam int Nlanes      = 4;
   localparam int AW          = N_mem_addr + 1;

   logic                   clk = 1'b0;
   logic                   rstb = 1'b1;
   logic signed [Nadc-1:0] in_data [Nlanes];
   logic                   in_valid = 1'b0;
   logic                   start = 1'b0;
   logic                   abort = 1'b0;
   logic                   trigger = 1'b0;
   logic [AW-1:0]          in_addr = '0;
   logic                   sel_sram = 1'b0;
   logic signed [Nadc-1:0] out_data [Nlanes];
   logic [AW-1:0]          addr;
   logic                   done;
   logic                   busy;

   int checks = 0;
   int errors = 0;
   int nwr;

   logic signed [Nadc-1:0] mem_model [N_mem_tiles][16][Nlanes];

   sram_capture_ctrl_if #(
      .N_mem_tiles(N_mem_tiles), .N_mem_addr(N_mem_addr), .Nadc(Nadc), .Nlanes(Nlanes)
   ) bus ();

   sram_capture_ctrl #(
      .N_mem_tiles(N_mem_tiles), .N_mem_addr(N_mem_addr), .Nadc(Nadc), .Nlanes(Nlanes)
   ) dut (
      .clk      (clk),
      .rstb     (rstb),
      .in_data  (in_data),
      .in_valid (in_valid),
      .start    (start),
      .abort    (abort),
      .trigger  (trigger),
      .mem      (bus.master),
      .in_addr  (in_addr),
      .sel_sram (sel_sram),
      .out_data (out_data),
      .addr     (addr),
      .done     (done),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   // Single-port tile model: read data appears one cycle after the address.
   always @(posedge clk) begin
      for (int t = 0; t < N_mem_tiles; t++) begin
         if (bus.mem_wr_en[t])
            mem_model[t][bus.mem_addr] <= bus.mem_wdata;
         bus.mem_rdata[t] <= mem_model[t][bus.mem_addr];
      end
   end

   task automatic check_eq(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_word(input int v);
      for (int l = 0; l < Nlanes; l++)
         in_data[l] = Nadc'(v + 32 * l);
   endtask

   task automatic check_zero_outputs(input string tag);
      check_eq({tag, "_wr_en"}, int'(bus.mem_wr_en), 0);
      check_eq({tag, "_mem_addr"}, int'(bus.mem_addr), 0);
      check_eq({tag, "_wdata0"}, int'(bus.mem_wdata[0]), 0);
      check_eq({tag, "_out0"}, int'(out_data[0]), 0);
      check_eq({tag, "_addr"}, int'(addr), 0);
      check_eq({tag, "_done"}, int'(done), 0);
      check_eq({tag, "_busy"}, int'(busy), 0);
   endtask

   initial begin
      set_word(0);
      #2 rstb = 1'b0;
      #1 check_zero_outputs("reset");
      tick(); tick();
      @(negedge clk) rstb = 1'b1;

      // Full 32-word capture across both tiles
      start = 1'b1; tick(); start = 1'b0;
      check_eq("armed_busy", int'(busy), 1);
      in_valid = 1'b1;
      for (int i = 0; i < 32; i++) begin
         set_word(i);
         trigger = (i == 0);
         tick();
         check_eq($sformatf("full_wr_en_%0d", i), int'(bus.mem_wr_en), (i < 16) ? 1 : 2);
         check_eq($sformatf("full_row_%0d", i), int'(bus.mem_addr), i % 16);
         check_eq($sformatf("full_wdata_%0d", i), int'(bus.mem_wdata[0]), i);
      end
      trigger = 1'b0;
      set_word(0);
      tick();
      check_eq("full_no_33rd", int'(bus.mem_wr_en), 0);
      check_eq("full_done", int'(done), 1);
      check_eq("full_addr", int'(addr), 31);
      check_eq("full_busy", int'(busy), 0);
      tick();
      check_eq("full_still_idle", int'(bus.mem_wr_en), 0);
      in_valid = 1'b0;

      // Readback: 3-cycle latency, then pipelined back-to-back reads
      sel_sram = 1'b1;
      in_addr = AW'(17);
      tick(); tick(); tick();
      check_eq("rd17_lane0", int'(out_data[0]), 17);
      check_eq("rd17_lane3", int'(out_data[3]), 17 + 96);
      in_addr = AW'(0); tick();
      in_addr = AW'(1); tick();
      in_addr = AW'(2); tick();
      check_eq("rd0_lane0", int'(out_data[0]), 0);
      tick();
      check_eq("rd1_lane0", int'(out_data[0]), 1);
      tick();
      check_eq("rd2_lane0", int'(out_data[0]), 2);
      check_eq("rd2_lane2", int'(out_data[2]), 2 + 64);
      sel_sram = 1'b0;

      // abort beats start in DONE
      abort = 1'b1; start = 1'b1; tick(); abort = 1'b0; start = 1'b0;
      check_eq("abst_done", int'(done), 0);
      check_eq("abst_busy", int'(busy), 0);
      check_eq("abst_addr_kept", int'(addr), 31);
      trigger = 1'b1; in_valid = 1'b1; set_word(9); tick();
      check_eq("abst_no_capture", int'(bus.mem_wr_en), 0);
      trigger = 1'b0; in_valid = 1'b0;

      // Trigger with no valid data, then three words
      start = 1'b1; tick(); start = 1'b0;
      check_eq("arm_addr_held", int'(addr), 31);
      trigger = 1'b1; tick(); trigger = 1'b0;
      check_eq("trig_novalid_wr_en", int'(bus.mem_wr_en), 0);
      check_eq("trig_novalid_busy", int'(busy), 1);
      in_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         set_word(40 + k);
         tick();
         check_eq($sformatf("three_wr_en_%0d", k), int'(bus.mem_wr_en), 1);
         check_eq($sformatf("three_row_%0d", k), int'(bus.mem_addr), k);
      end
      in_valid = 1'b0; tick();
      check_eq("three_addr", int'(addr), 2);
      check_eq("three_busy", int'(busy), 1);
      check_eq("three_done", int'(done), 0);
      abort = 1'b1; tick(); abort = 1'b0;
      check_eq("three_abort_busy", int'(busy), 0);

      // abort on the 8th valid word suppresses that write
      nwr = 0;
      start = 1'b1; tick(); start = 1'b0;
      in_valid = 1'b1;
      for (int k = 0; k < 8; k++) begin
         set_word(k);
         trigger = (k == 0);
         abort   = (k == 7);
         tick();
         if (bus.mem_wr_en != 0) nwr++;
      end
      trigger = 1'b0; abort = 1'b0; in_valid = 1'b0;
      check_eq("abort8_writes", nwr, 7);
      check_eq("abort8_addr", int'(addr), 6);
      check_eq("abort8_busy", int'(busy), 0);
      check_eq("abort8_done", int'(done), 0);

      // Asynchronous reset after 5 capture writes
      start = 1'b1; tick(); start = 1'b0;
      in_valid = 1'b1;
      for (int k = 0; k < 5; k++) begin
         set_word(20 + k);
         trigger = (k == 0);
         tick();
      end
      trigger = 1'b0;
      check_eq("midcap_addr", int'(addr), 4);
      #2 rstb = 1'b0;
      #1 check_zero_outputs("async_rst");
      in_valid = 1'b0;
      @(negedge clk) rstb = 1'b1;
      start = 1'b1; tick(); start = 1'b0;
      trigger = 1'b1; in_valid = 1'b1; set_word(5); tick();
      trigger = 1'b0; in_valid = 1'b0;
      check_eq("post_rst_wr_en", int'(bus.mem_wr_en), 1);
      check_eq("post_rst_row", int'(bus.mem_addr), 0);
      check_eq("post_rst_addr", int'(addr), 0);
      check_eq("post_rst_wdata", int'(bus.mem_wdata[0]), 5);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
